// File: rtl/fc_result_scorer.sv
// Result scorer for the fc_top_ip logit stream: argmax over N_CLASS logits per sample,
// label matching through a one-entry buffer, run counters and accumulator magnitude tracking.
module fc_result_scorer #(
    parameter int DATA_W    = 36,
    parameter int N_CLASS   = 2,
    parameter int N_SAMPLES = 42,
    parameter int CLS_W     = $clog2(N_CLASS),
    parameter int CNT_W     = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          clear_i,
    input  logic [DATA_W-1:0]             logit_i,
    input  logic                          logit_vld_i,
    input  logic [DATA_W-1:0]             acc_i,
    input  logic                          acc_vld_i,
    input  logic [CLS_W-1:0]              label_i,
    input  logic                          label_vld_i,
    output logic                          label_rdy_o,
    output logic [CLS_W-1:0]              pred_o,
    output logic                          pred_vld_o,
    output logic                          hit_o,
    output logic [CNT_W-1:0]              sample_cnt_o,
    output logic [CNT_W-1:0]              correct_cnt_o,
    output logic [DATA_W-1:0]             max_abs_o,
    output logic [$clog2(DATA_W+2)-1:0]   req_bits_o,
    output logic                          overrun_o,
    output logic                          done_o
);
    localparam int REQ_W = $clog2(DATA_W + 2);

    typedef enum logic [1:0] {IDLE, COLLECT, WAIT_LBL, DONE} state_t;

    state_t                    state;
    logic                      vld_d;
    logic                      full;
    logic [CLS_W-1:0]          lbl;
    logic [CLS_W-1:0]          k;
    logic [CLS_W-1:0]          best_idx;
    logic signed [DATA_W-1:0]  best_val;
    logic [DATA_W-1:0]         acc_abs;
    logic [REQ_W-1:0]          req_next;
    logic [CNT_W-1:0]          sample_next;
    logic                      edge_seen;
    logic                      lbl_take;
    logic                      hit_now;

    assign edge_seen   = logit_vld_i & ~vld_d;
    assign lbl_take    = label_vld_i & ~full & (state != DONE);
    assign label_rdy_o = ~full;
    // Labels outside the class range can never equal best_idx, so they score a miss naturally.
    assign hit_now     = (best_idx == lbl);
    assign sample_next = sample_cnt_o + CNT_W'(1);
    assign acc_abs     = acc_i[DATA_W-1] ? (~acc_i + {{(DATA_W-1){1'b0}}, 1'b1}) : acc_i;

    // Signed width of max_abs_o: magnitude bits (at least one) plus a sign bit.
    always_comb begin
        req_next = REQ_W'(2);
        for (int i = 1; i < DATA_W; i++) begin
            if (max_abs_o[i]) req_next = REQ_W'(i + 2);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= IDLE;
            vld_d         <= 1'b0;
            full          <= 1'b0;
            lbl           <= '0;
            k             <= '0;
            best_idx      <= '0;
            best_val      <= '0;
            pred_o        <= '0;
            pred_vld_o    <= 1'b0;
            hit_o         <= 1'b0;
            sample_cnt_o  <= '0;
            correct_cnt_o <= '0;
            max_abs_o     <= '0;
            req_bits_o    <= REQ_W'(2);
            overrun_o     <= 1'b0;
            done_o        <= 1'b0;
        end else if (clear_i) begin
            state         <= IDLE;
            vld_d         <= 1'b0;
            full          <= 1'b0;
            lbl           <= '0;
            k             <= '0;
            best_idx      <= '0;
            best_val      <= '0;
            pred_o        <= '0;
            pred_vld_o    <= 1'b0;
            hit_o         <= 1'b0;
            sample_cnt_o  <= '0;
            correct_cnt_o <= '0;
            max_abs_o     <= '0;
            req_bits_o    <= REQ_W'(2);
            overrun_o     <= 1'b0;
            done_o        <= 1'b0;
        end else begin
            vld_d      <= logit_vld_i;
            pred_vld_o <= 1'b0;
            req_bits_o <= req_next;
            if (acc_vld_i && (acc_abs > max_abs_o)) max_abs_o <= acc_abs;
            if (lbl_take) begin
                full <= 1'b1;
                lbl  <= label_i;
            end
            case (state)
                IDLE: begin
                    if (edge_seen) begin
                        best_idx <= '0;
                        best_val <= logit_i;
                        k        <= CLS_W'(1);
                        state    <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (edge_seen) overrun_o <= 1'b1;
                    // >= lets a later class win a tie.
                    if ($signed(logit_i) >= best_val) begin
                        best_val <= logit_i;
                        best_idx <= k;
                    end
                    if (k == CLS_W'(N_CLASS - 1)) state <= WAIT_LBL;
                    else k <= k + CLS_W'(1);
                end
                WAIT_LBL: begin
                    if (edge_seen) overrun_o <= 1'b1;
                    if (full) begin
                        pred_o       <= best_idx;
                        hit_o        <= hit_now;
                        pred_vld_o   <= 1'b1;
                        sample_cnt_o <= sample_next;
                        if (hit_now) correct_cnt_o <= correct_cnt_o + CNT_W'(1);
                        full   <= 1'b0;
                        done_o <= (sample_next == CNT_W'(N_SAMPLES));
                        state  <= (sample_next == CNT_W'(N_SAMPLES)) ? DONE : IDLE;
                    end
                end
                DONE: done_o <= 1'b1;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
